// File: rtl/interlock_axil_arbiter.sv
// Two-requester round-robin arbiter driving one AXI4-Lite master port.
// Latency: accept at T, AW/W or AR at T+1, resp_valid at T+3 with a zero-wait slave; one transaction in flight.
// Backpressure: req_ready only in IDLE; AXI VALIDs held until handshake; responses cannot be stalled.
module interlock_axil_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_ERR_CNT_WIDTH    = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [1:0]                        req_valid,
  output logic [1:0]                        req_ready,
  input  logic [1:0]                        req_we,
  input  logic [2*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*C_M_AXI_DATA_WIDTH-1:0]   req_wdata,
  output logic [1:0]                        resp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     resp_rdata,
  output logic                              resp_err,
  output logic                              busy,
  output logic [C_ERR_CNT_WIDTH-1:0]        err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t          state;
  logic            last_grant;
  logic            grant;
  logic            win;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            aw_ok;
  logic            w_ok;
  logic            unused_bits;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win = req_valid[1];
    if (req_valid == 2'b11) win = ~last_grant;
    req_ready = 2'b00;
    if (ARESETN && state == IDLE && req_valid != 2'b00) req_ready = win ? 2'b10 : 2'b01;
  end

  assign sel_we    = win ? req_we[1] : req_we[0];
  assign sel_addr  = win ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign sel_wdata = win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];

  assign aw_ok = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_ok  = !M_AXI_WVALID || M_AXI_WREADY;

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = {(DW/8){1'b1}};
  assign busy         = (state != IDLE);

  assign unused_bits = &{1'b0, M_AXI_BRESP[0], M_AXI_RRESP[0], req_addr[AW+1:AW], req_addr[1:0]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      resp_valid    <= 2'b00;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      err_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready != 2'b00) begin
            grant      <= win;
            last_grant <= win;
            addr_q     <= {sel_addr[AW-1:2], 2'b00};
            wdata_q    <= sel_wdata;
            if (sel_we) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR_ADDR;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        // AW and W retire independently; move on once neither is pending.
        WR_ADDR: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
          if (aw_ok && w_ok) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            resp_err     <= M_AXI_BRESP[1];
            resp_rdata   <= '0;
            resp_valid   <= grant ? 2'b10 : 2'b01;
            state        <= DONE;
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            resp_err     <= M_AXI_RRESP[1];
            resp_rdata   <= M_AXI_RDATA;
            resp_valid   <= grant ? 2'b10 : 2'b01;
            state        <= DONE;
          end
        end
        DONE: begin
          resp_valid <= 2'b00;
          if (resp_err && err_count != {C_ERR_CNT_WIDTH{1'b1}}) err_count <= err_count + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interlock_axil_arbiter.sv
// Bench for interlock_axil_arbiter: command queues per requester, a configurable AXI4-Lite slave,
// and a scoreboard monitor that checks every resp_valid pulse against the expectation pushed at acceptance.
module tb_interlock_axil_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [7:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [15:0] err_count;
  logic [3:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  interlock_axil_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .err_count(err_count),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  // ---------------- slave model ----------------
  logic [31:0] mem [4];
  int          aw_wait = 0, w_wait = 0, r_wait = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  int          aw_cnt, w_cnt, r_cnt;
  logic        got_aw, got_w, rd_pend;
  logic [3:0]  aw_addr_s, ar_addr_s;
  logic [31:0] w_dat_s;
  logic        aw_hs, w_hs, aw_have, w_have;
  logic [3:0]  wr_addr_eff;
  logic [31:0] wr_dat_eff;

  assign AWREADY     = AWVALID && (aw_cnt >= aw_wait);
  assign WREADY      = WVALID && (w_cnt >= w_wait);
  assign ARREADY     = ARVALID;
  assign aw_hs       = AWVALID && AWREADY;
  assign w_hs        = WVALID && WREADY;
  assign aw_have     = got_aw || aw_hs;
  assign w_have      = got_w || w_hs;
  assign wr_addr_eff = aw_hs ? AWADDR : aw_addr_s;
  assign wr_dat_eff  = w_hs ? WDATA : w_dat_s;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; rd_pend <= 1'b0;
      aw_addr_s <= '0; ar_addr_s <= '0; w_dat_s <= '0;
      BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RRESP <= 2'b00; RDATA <= '0;
    end else begin
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
      if (aw_hs) aw_addr_s <= AWADDR;
      if (w_hs) w_dat_s <= WDATA;
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (aw_have && w_have) begin
        mem[wr_addr_eff[3:2]] <= wr_dat_eff;
        BVALID <= 1'b1;
        BRESP  <= bresp_cfg;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end else begin
        got_aw <= aw_have;
        got_w  <= w_have;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        if (r_wait == 0) begin
          RVALID <= 1'b1; RDATA <= mem[ARADDR[3:2]]; RRESP <= rresp_cfg;
        end else begin
          rd_pend <= 1'b1; r_cnt <= r_wait; ar_addr_s <= ARADDR;
        end
      end else if (rd_pend) begin
        if (r_cnt <= 1) begin
          rd_pend <= 1'b0; RVALID <= 1'b1; RDATA <= mem[ar_addr_s[3:2]]; RRESP <= rresp_cfg;
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end
    end
  end

  // ---------------- scoreboard / bookkeeping ----------------
  typedef struct { int r; logic [31:0] rdata; logic err; } exp_t;
  typedef struct { logic we; logic [3:0] addr; logic [31:0] wdata; logic [31:0] exp_rdata; logic exp_err; } cmd_t;

  exp_t sbq[$];
  cmd_t q0[$], q1[$];
  int   grant_log[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   last_hs_cyc = 0, last_resp_cyc = 0, last_busy_len = 0, n_resp = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response and AXI-protocol monitor, sampled on the falling edge.
  initial begin
    exp_t       e;
    int         busy_run = 0;
    logic       aw_pend = 0, w_pend = 0, ar_pend = 0;
    logic [3:0]  aw_prev = '0, ar_prev = '0;
    logic [31:0] w_prev = '0;
    forever begin
      @(negedge ACLK);
      if (resp_valid != 2'b00) begin
        if (sbq.size() == 0) begin
          chk("spurious_resp_valid", 32'(resp_valid), 32'h0);
        end else begin
          e = sbq.pop_front();
          chk("resp_valid_grant", 32'(resp_valid), (e.r == 1) ? 32'h2 : 32'h1);
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          last_resp_cyc = cyc;
          n_resp++;
        end
      end
      if (busy) busy_run++;
      else begin
        if (busy_run != 0) last_busy_len = busy_run;
        busy_run = 0;
      end
      if (ARESETN) begin
        if (aw_pend) begin chk("awvalid_hold", 32'(AWVALID), 32'h1); chk("awaddr_hold", 32'(AWADDR), 32'(aw_prev)); end
        if (w_pend)  begin chk("wvalid_hold", 32'(WVALID), 32'h1); chk("wdata_hold", WDATA, w_prev); end
        if (ar_pend) begin chk("arvalid_hold", 32'(ARVALID), 32'h1); chk("araddr_hold", 32'(ARADDR), 32'(ar_prev)); end
        if (aw_hs) begin
          chk("awaddr_align", 32'(AWADDR[1:0]), 32'h0);
          chk("awprot", 32'(AWPROT), 32'h0);
          chk("wstrb", 32'(WSTRB), 32'hF);
        end
        if (ARVALID && ARREADY) begin
          chk("araddr_align", 32'(ARADDR[1:0]), 32'h0);
          chk("arprot", 32'(ARPROT), 32'h0);
        end
        aw_pend = AWVALID && !AWREADY; aw_prev = AWADDR;
        w_pend  = WVALID && !WREADY;   w_prev  = WDATA;
        ar_pend = ARVALID && !ARREADY; ar_prev = ARADDR;
      end else begin
        aw_pend = 0; w_pend = 0; ar_pend = 0;
      end
    end
  end

  // Presents queued commands; the expectation is pushed at the accepting handshake.
  task automatic run_cmds();
    int         budget;
    logic [1:0] hs;
    budget = 400;
    while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
      req_valid[0] = (q0.size() > 0);
      req_valid[1] = (q1.size() > 0);
      if (q0.size() > 0) begin req_we[0] = q0[0].we; req_addr[3:0] = q0[0].addr; req_wdata[31:0] = q0[0].wdata; end
      if (q1.size() > 0) begin req_we[1] = q1[0].we; req_addr[7:4] = q1[0].addr; req_wdata[63:32] = q1[0].wdata; end
      @(negedge ACLK);
      hs = req_ready & req_valid;
      if (hs[0]) begin
        sbq.push_back('{0, q0[0].exp_rdata, q0[0].exp_err});
        grant_log.push_back(0); last_hs_cyc = cyc; void'(q0.pop_front());
      end else if (hs[1]) begin
        sbq.push_back('{1, q1[0].exp_rdata, q1[0].exp_err});
        grant_log.push_back(1); last_hs_cyc = cyc; void'(q1.pop_front());
      end
      @(posedge ACLK); #1;
      budget--;
    end
    req_valid = 2'b00;
    if (budget == 0) chk("cmd_accept_timeout", 32'(q0.size() + q1.size()), 32'h0);
    budget = 100;
    while (sbq.size() > 0 && budget > 0) begin
      @(posedge ACLK); budget--;
    end
    repeat (2) @(posedge ACLK);
    #1;
    if (budget == 0) chk("resp_timeout", 32'(sbq.size()), 32'h0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'h0);
    chk({tag, "_err_count"}, 32'(err_count), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_awvalid"}, 32'(AWVALID), 32'h0);
    chk({tag, "_wvalid"}, 32'(WVALID), 32'h0);
    chk({tag, "_bready"}, 32'(BREADY), 32'h0);
    chk({tag, "_arvalid"}, 32'(ARVALID), 32'h0);
    chk({tag, "_rready"}, 32'(RREADY), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   budget;
    int   n0;
    logic seen;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset("por");
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Both requesters contend: grants must alternate starting with requester 0.
    q0.push_back('{1'b1, 4'h0, 32'hAAAA_0000, 32'h0, 1'b0});
    q0.push_back('{1'b1, 4'h0, 32'hAAAA_0001, 32'h0, 1'b0});
    q1.push_back('{1'b1, 4'h4, 32'h5555_0000, 32'h0, 1'b0});
    q1.push_back('{1'b1, 4'h4, 32'h5555_0001, 32'h0, 1'b0});
    grant_log.delete();
    run_cmds();
    for (int i = 0; i < 4; i++)
      chk($sformatf("grant_order_%0d", i), (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(i % 2));
    q0.push_back('{1'b0, 4'h0, 32'h0, 32'hAAAA_0001, 1'b0});
    q1.push_back('{1'b0, 4'h5, 32'h0, 32'h5555_0001, 1'b0});
    run_cmds();

    // Requester 0 fills all four registers and reads them back.
    for (int i = 0; i < 4; i++) q0.push_back('{1'b1, 4'(i * 4), 32'(i + 1), 32'h0, 1'b0});
    for (int i = 0; i < 4; i++) q0.push_back('{1'b0, 4'(i * 4), 32'h0, 32'(i + 1), 1'b0});
    run_cmds();
    chk("err_count_clean", 32'(err_count), 32'h0);

    // Single zero-wait write: latency and busy width.
    q0.push_back('{1'b1, 4'hC, 32'h4, 32'h0, 1'b0});
    run_cmds();
    chk("write_latency", 32'(last_resp_cyc - last_hs_cyc), 32'h3);
    chk("busy_cycles", 32'(last_busy_len), 32'h3);

    // AW accepted well before W, then W before AW.
    n0 = n_resp;
    w_wait = 3;
    q0.push_back('{1'b1, 4'h8, 32'h1234_5678, 32'h0, 1'b0});
    run_cmds();
    w_wait = 0; aw_wait = 3;
    q0.push_back('{1'b1, 4'hC, 32'h9ABC_DEF0, 32'h0, 1'b0});
    run_cmds();
    aw_wait = 0;
    chk("stall_resp_pulses", 32'(n_resp - n0), 32'h2);
    q0.push_back('{1'b0, 4'h8, 32'h0, 32'h1234_5678, 1'b0});
    q1.push_back('{1'b0, 4'hC, 32'h0, 32'h9ABC_DEF0, 1'b0});
    run_cmds();

    // Error responses: two SLVERR writes, one DECERR read.
    bresp_cfg = 2'b10;
    q0.push_back('{1'b1, 4'h0, 32'h11, 32'h0, 1'b1});
    q1.push_back('{1'b1, 4'h4, 32'h22, 32'h0, 1'b1});
    run_cmds();
    bresp_cfg = 2'b00; rresp_cfg = 2'b11;
    q0.push_back('{1'b0, 4'h0, 32'h0, 32'h11, 1'b1});
    run_cmds();
    rresp_cfg = 2'b00;
    chk("err_count_three", 32'(err_count), 32'h3);

    // Reset while waiting in RD_DATA: no completion, then a normal read.
    r_wait = 6;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[3:0] = 4'h8;
    budget = 20; seen = 1'b0;
    while (!seen && budget > 0) begin
      @(negedge ACLK);
      seen = req_ready[0];
      @(posedge ACLK); #1;
      budget--;
    end
    req_valid = 2'b00;
    chk("abort_cmd_accepted", 32'(seen), 32'h1);
    budget = 20; seen = 1'b0;
    while (!seen && budget > 0) begin
      @(negedge ACLK);
      seen = RREADY;
      budget--;
    end
    chk("abort_reached_rd_data", 32'(seen), 32'h1);
    ARESETN = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check_reset("mid_rst");
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    r_wait = 0;
    repeat (10) @(posedge ACLK);
    #1;
    q0.push_back('{1'b0, 4'h8, 32'h0, 32'h1234_5678, 1'b0});
    run_cmds();

    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
